// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: sequencing controller for a 2-way LRU data cache
// (32 sets x 2 ways x 4 words). It serves CPU loads and stores. On a miss it
// writes back a dirty LRU victim line and refills the line word by word from
// memory. It then replays the held request, which hits.
module cache_ctrl_fsm #(
    parameter int ADDR_BITS           = 32,
    parameter int TAG_BITS            = 23,
    parameter int SET_INDEX_WIDTH     = 5,
    parameter int ELEMENT_WORDS_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [2:0]           u_b_h_w,
    input  logic [ADDR_BITS-1:0] addr_rw,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    output logic                 ack,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic                 cache_invalid,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [31:0]          cache_dout,
    output logic                 mem_cs_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_LO = 2 + ELEMENT_WORDS_WIDTH;
    localparam int TAG_LO = IDX_LO + SET_INDEX_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_BACK_RD,
        S_BACK_WR,
        S_FILL
    } state_t;

    state_t                         state, state_nxt;
    logic [ELEMENT_WORDS_WIDTH-1:0] word_cnt, word_cnt_nxt;
    logic [TAG_BITS-1:0]            victim_tag, victim_tag_nxt;
    logic [ADDR_BITS-1:0]           victim_addr;
    logic [ADDR_BITS-1:0]           fill_addr;
    logic                           last_word;
    logic                           is_read;

    assign victim_addr = {victim_tag, addr_rw[TAG_LO-1:IDX_LO], word_cnt, 2'b00};
    assign fill_addr   = {addr_rw[ADDR_BITS-1:IDX_LO], word_cnt, 2'b00};
    assign last_word   = &word_cnt;
    // Both enables high counts as a write.
    assign is_read     = en_r & ~en_w;

    // State, word counter and captured victim tag; reset abandons any transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            victim_tag <= '0;
        end else begin
            state      <= state_nxt;
            word_cnt   <= word_cnt_nxt;
            victim_tag <= victim_tag_nxt;
        end
    end

    // Next-state and output decode; every output is forced to 0 while reset is held
    always_comb begin
        state_nxt      = state;
        word_cnt_nxt   = word_cnt;
        victim_tag_nxt = victim_tag;
        data_r         = '0;
        ack            = 1'b0;
        cache_addr     = '0;
        cache_load     = 1'b0;
        cache_edit     = 1'b0;
        cache_store    = 1'b0;
        cache_invalid  = 1'b0;
        cache_u_b_h_w  = '0;
        cache_din      = '0;
        mem_cs_o       = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        if (rst) begin
            cache_u_b_h_w = u_b_h_w;
            unique case (state)
                S_IDLE: begin
                    cache_addr = addr_rw;
                    cache_load = is_read;
                    cache_edit = en_w;
                    cache_din  = data_w;
                    if (en_r | en_w) state_nxt = S_CHECK;
                end
                S_CHECK: begin
                    cache_addr = addr_rw;
                    if (cache_hit) begin
                        ack       = 1'b1;
                        data_r    = is_read ? cache_dout : '0;
                        state_nxt = S_IDLE;
                    end else if (cache_valid & cache_dirty) begin
                        victim_tag_nxt = cache_tag;
                        word_cnt_nxt   = '0;
                        state_nxt      = S_BACK_RD;
                    end else begin
                        word_cnt_nxt = '0;
                        state_nxt    = S_FILL;
                    end
                end
                S_BACK_RD: begin
                    // Plain read of the victim word without an LRU update; its
                    // data appears on cache_dout during S_BACK_WR.
                    cache_addr = victim_addr;
                    state_nxt  = S_BACK_WR;
                end
                S_BACK_WR: begin
                    cache_addr = victim_addr;
                    mem_cs_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_addr_o = victim_addr;
                    mem_data_o = cache_dout;
                    if (mem_ack_i) begin
                        word_cnt_nxt = word_cnt + 1'b1;
                        state_nxt    = last_word ? S_FILL : S_BACK_RD;
                    end
                end
                S_FILL: begin
                    mem_cs_o   = 1'b1;
                    mem_addr_o = fill_addr;
                    cache_addr = fill_addr;
                    if (mem_ack_i) begin
                        cache_store  = 1'b1;
                        cache_din    = mem_data_i;
                        word_cnt_nxt = word_cnt + 1'b1;
                        if (last_word) state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
        stall = rst & (en_r | en_w) & ~ack;
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Testbench for cache_ctrl_fsm. It contains a behavioural 2-way LRU cache, a
// variable-latency memory, and a reference model. The reference model tracks
// resident lines, the dirty set and the CPU-visible memory image.
module tb_cache_ctrl_fsm;

    localparam logic [2:0] UW = 3'b010;   // full word
    localparam logic [2:0] UB = 3'b000;   // byte, lane = addr[1:0]

    logic        clk = 1'b0, rst = 1'b0;
    logic        en_r = 1'b0, en_w = 1'b0;
    logic [2:0]  u_b_h_w = UW;
    logic [31:0] addr_rw = '0, data_w = '0;
    logic [31:0] data_r, cache_addr, cache_din, mem_addr_o, mem_data_o;
    logic        ack, stall, cache_load, cache_edit, cache_store, cache_invalid;
    logic [2:0]  cache_u_b_h_w;
    logic        mem_cs_o, mem_we_o;
    logic        cache_hit = 1'b0, cache_valid = 1'b0, cache_dirty = 1'b0;
    logic [22:0] cache_tag = '0;
    logic [31:0] cache_dout = '0;
    logic [31:0] mem_data_i = '0;
    logic        mem_ack_i = 1'b0;

    always #5 clk = ~clk;

    cache_ctrl_fsm #(.ADDR_BITS(32), .TAG_BITS(23), .SET_INDEX_WIDTH(5), .ELEMENT_WORDS_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .u_b_h_w(u_b_h_w),
        .addr_rw(addr_rw), .data_w(data_w), .data_r(data_r), .ack(ack), .stall(stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
        .cache_store(cache_store), .cache_invalid(cache_invalid),
        .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din), .cache_hit(cache_hit),
        .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
        .cache_dout(cache_dout), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i)
    );

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] w, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        if (w == UB) r[{off, 3'b000} +: 8] = d[7:0];
        else r = d;
        return r;
    endfunction

    // ---------------- behavioural cache (registered outputs) ----------------
    logic [22:0] ctag [32][2] = '{default: '0};
    logic        cval [32][2] = '{default: 1'b0};
    logic        cdir [32][2] = '{default: 1'b0};
    logic [31:0] cdat [32][2][4] = '{default: '0};
    logic        clru [32] = '{default: 1'b0};

    logic [4:0]  cs_s;
    logic [22:0] cs_t;
    logic [1:0]  cs_w;
    logic        c_h0, c_h1, c_hit, c_way;
    assign cs_s  = cache_addr[8:4];
    assign cs_t  = cache_addr[31:9];
    assign cs_w  = cache_addr[3:2];
    assign c_h0  = cval[cs_s][0] && (ctag[cs_s][0] == cs_t);
    assign c_h1  = cval[cs_s][1] && (ctag[cs_s][1] == cs_t);
    assign c_hit = c_h0 | c_h1;
    assign c_way = c_h0 ? 1'b0 : (c_h1 ? 1'b1 : clru[cs_s]);

    always @(posedge clk) begin
        cache_hit   <= c_hit;
        cache_valid <= cval[cs_s][c_way];
        cache_dirty <= cdir[cs_s][c_way];
        cache_tag   <= ctag[cs_s][c_way];
        cache_dout  <= cdat[cs_s][c_way][cs_w];
        if (cache_store) begin
            cdat[cs_s][c_way][cs_w] <= cache_din;
            if (!c_hit) begin
                ctag[cs_s][c_way] <= cs_t;
                cval[cs_s][c_way] <= 1'b1;
                cdir[cs_s][c_way] <= 1'b0;
            end
        end else if (cache_edit && c_hit) begin
            cdat[cs_s][c_way][cs_w] <= merge(cdat[cs_s][c_way][cs_w], cache_din, cache_u_b_h_w, cache_addr[1:0]);
            cdir[cs_s][c_way] <= 1'b1;
            clru[cs_s] <= ~c_way;
        end else if (cache_load && c_hit) begin
            clru[cs_s] <= ~c_way;
        end
    end

    // ---------------- memory with per-word latency cur_lat ----------------
    typedef struct packed { logic we; logic [31:0] a; logic [31:0] d; } op_t;
    op_t         mem_log[$];
    logic [31:0] mem [logic [31:0]];
    int unsigned cur_lat = 1;
    int unsigned wait_cnt = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    function automatic op_t mk_op(input logic we, input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.we = we; o.a = a; o.d = d;
        return o;
    endfunction

    initial begin : responder
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (!rst || !mem_cs_o) wait_cnt = cur_lat - 1;
            else if (wait_cnt != 0) wait_cnt--;
            else begin
                if (mem_we_o) mem[mem_addr_o] = mem_data_o;
                else mem_data_i = mem_rd(mem_addr_o);
                mem_log.push_back(mk_op(mem_we_o, mem_addr_o, mem_we_o ? mem_data_o : mem_data_i));
                mem_ack_i = 1'b1;
                wait_cnt  = cur_lat - 1;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0] truth [logic [31:0]];
    bit          dirty_ln [logic [27:0]];
    logic [27:0] res_q[$];   // resident lines, least recently used first

    function automatic logic [31:0] truth_rd(input logic [31:0] a);
        return truth.exists(a) ? truth[a] : pat(a);
    endfunction

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] w, input int unsigned lat, input string tag);
        op_t         exp_q[$];
        int unsigned exp_lat, cnt, base;
        logic [31:0] exp_data, wa;
        logic [27:0] line, v;
        int          hi, vi, n_set;
        bit          wb, done, stall_ok;
        line = a[31:4]; hi = -1; vi = -1; n_set = 0; wb = 0; done = 0; stall_ok = 1;
        foreach (res_q[i]) begin
            if (res_q[i] == line) hi = i;
            if (res_q[i][4:0] == line[4:0]) begin
                n_set++;
                if (vi < 0) vi = i;
            end
        end
        if (hi >= 0) begin
            res_q.delete(hi);
            exp_lat = 1;
        end else begin
            if (n_set == 2) begin
                v = res_q[vi];
                if (dirty_ln.exists(v)) begin
                    wb = 1;
                    for (int unsigned k = 0; k < 4; k++) begin
                        wa = {v, k[1:0], 2'b00};
                        exp_q.push_back(mk_op(1'b1, wa, truth_rd(wa)));
                    end
                    dirty_ln.delete(v);
                end
                res_q.delete(vi);
            end
            for (int unsigned k = 0; k < 4; k++) begin
                wa = {line, k[1:0], 2'b00};
                exp_q.push_back(mk_op(1'b0, wa, truth_rd(wa)));
            end
            exp_lat = wb ? 8 * lat + 7 : 4 * lat + 3;
        end
        res_q.push_back(line);
        exp_data = truth_rd({a[31:2], 2'b00});
        if (wr) begin
            truth[{a[31:2], 2'b00}] = merge(exp_data, d, w, a[1:0]);
            dirty_ln[line] = 1;
        end

        cur_lat = lat;
        @(negedge clk);
        base = mem_log.size();
        en_r = !wr; en_w = wr; addr_rw = a; data_w = d; u_b_h_w = w;
        #1;
        chk({tag, ".stall_req"}, stall, 1);
        chk({tag, ".pass"}, {cache_invalid, cache_u_b_h_w}, {1'b0, w});
        cnt = 0;
        while (!done && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (ack) done = 1;
            else if (!stall) stall_ok = 0;
        end
        chk({tag, ".ack_seen"}, done, 1);
        chk({tag, ".latency"}, cnt, exp_lat);
        chk({tag, ".stall_held"}, {stall_ok, stall}, 2'b10);
        if (!wr) chk({tag, ".data_r"}, data_r, exp_data);
        @(negedge clk);
        en_r = 0; en_w = 0;
        @(posedge clk); #1;
        chk({tag, ".ack_pulse"}, ack, 0);
        chk({tag, ".n_mem_ops"}, mem_log.size() - base, exp_q.size());
        foreach (exp_q[i])
            if (base + i < mem_log.size())
                chk($sformatf("%s.mem_op%0d", tag, i), mem_log[base + i], exp_q[i]);
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin : stim
        int unsigned cnt, base;
        bit          reached;
        logic [31:0] a;
        bit          wr;
        logic [2:0]  w;

        // Reset holds all outputs low even with a request pending.
        rst = 0; en_r = 1; addr_rw = 32'h1234; data_w = 32'h55; u_b_h_w = UW;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.ctl", {ack, stall, cache_load, cache_edit, cache_store, cache_invalid, mem_cs_o, mem_we_o}, 0);
        chk("rst.data", {data_r, cache_addr, cache_din}, 0);
        chk("rst.mem", {mem_addr_o, mem_data_o, cache_u_b_h_w}, 0);
        en_r = 0;
        @(negedge clk); rst = 1;
        @(negedge clk);

        do_req(0, 32'h0000_1234, '0, UW, 3, "cold_rd_1234");
        do_req(1, 32'h0000_0013, 32'h0000_00AB, UB, 2, "sb_miss_13");
        do_req(0, 32'h0000_0010, '0, UW, 1, "rd_hit_10");
        do_req(0, 32'h0000_0200, '0, UW, 2, "rd_200");
        do_req(1, 32'h0000_0200, 32'hDEAD_BEEF, UW, 1, "sw_hit_200");
        do_req(0, 32'h0000_0400, '0, UW, 1, "rd_400");
        do_req(0, 32'h0000_0600, '0, UW, 2, "dirty_evict_600");
        do_req(0, 32'h0000_0800, '0, UW, 3, "clean_evict_800");
        do_req(1, 32'h0000_0604, 32'h1357_9BDF, UW, 1, "sw_hit_604");
        do_req(1, 32'h0000_0808, 32'h2468_ACE0, UW, 1, "sw_hit_808");

        // Reset in the middle of the write-back, while word 2 is on the bus.
        cur_lat = 2;
        @(negedge clk);
        base = mem_log.size();
        en_r = 1; en_w = 0; addr_rw = 32'h0000_0A00; u_b_h_w = UW;
        cnt = 0; reached = 0;
        while (!reached && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (mem_cs_o && mem_we_o && mem_addr_o[3:2] == 2'd2) reached = 1;
        end
        chk("abort.reached_word2", reached, 1);
        rst = 0;
        #1;
        chk("abort.ctl", {ack, stall, cache_load, cache_edit, cache_store, mem_cs_o, mem_we_o}, 0);
        chk("abort.bus", {cache_addr, mem_addr_o, mem_data_o}, 0);
        chk("abort.writes_done", mem_log.size() - base, 2);
        if (mem_log.size() > base) chk("abort.first_wr_addr", mem_log[base].a, 32'h600);
        @(negedge clk); en_r = 0;
        @(negedge clk); rst = 1;
        do_req(0, 32'h0000_0A00, '0, UW, 2, "after_abort_A00");

        // Random mix over a small set of lines to exercise hits and evictions.
        for (int unsigned n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            w  = (wr && $urandom_range(0, 1) == 1) ? UB : UW;
            a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 2)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            if (w == UB || !wr) a[1:0] = 2'($urandom_range(0, 3));
            do_req(wr, a, $urandom, w, $urandom_range(1, 4), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
